// File: rtl/sram_bank_arbiter_pkg.sv
// Shared types for the SRAM bank-group arbiter: arbitration state,
// read-tracking pipe entry and the requester index width helper.
package sram_arb_pkg;

  // Widest requester index a read-pipe entry can carry (up to 256 requesters).
  localparam int unsigned IDX_MAX_W = 8;

  // Requester index width for a given requester count ($clog2, at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned num_req);
    if (num_req > 32'd1) begin
      return $clog2(num_req);
    end else begin
      return 32'd1;
    end
  endfunction

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } rd_entry_t;

endpackage

// File: rtl/sram_bank_arbiter_rr_pick.sv
// Round-robin priority picker: grants the first requester at or after the
// pointer, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [31:0] w_best;
  logic [31:0] w_dist;

  // Pick the requesting index with the smallest circular distance from the pointer
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_best = NUM_REQ;
    w_dist = 32'd0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i >= 32'(i_ptr)) begin
        w_dist = i - 32'(i_ptr);
      end else begin
        w_dist = i + NUM_REQ - 32'(i_ptr);
      end
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDX_W'(i);
        o_any  = 1'b1;
      end else begin
        w_best = w_best;
      end
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end else begin
      o_gnt = '0;
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares one SRAM bank-group port between NUM_REQ single-beat requesters with
// round-robin arbitration, burst grant locking, registered macro outputs and
// read-response routing through a READ_LATENCY-deep tracking pipe.
module sram_bank_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_HOLD     = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0]                    req_we_i,
  input  logic [NUM_REQ-1:0]                    req_lock_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  req_be_i,
  output logic [NUM_REQ-1:0]                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata_o,
  output logic                                  mem_cs_o,
  output logic                                  mem_we_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]               mem_be_o,
  output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i
);

  localparam int unsigned IDX_W  = idx_width(NUM_REQ);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt, w_hold_inc;
  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_accept;

  logic                r_mem_cs, r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [BE_W-1:0]     r_mem_be;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [IDX_W-1:0]    r_mem_idx;
  rd_entry_t           r_pipe [READ_LATENCY];

  // Pointer advance with explicit wrap for non-power-of-two requester counts.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    if (g == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return g + IDX_W'(1);
    end
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Grant: round-robin pick when free, only the owner while a burst is locked
  always_comb begin
    req_ready_o = '0;
    w_gnt_idx   = '0;
    case (r_state)
      ARB: begin
        req_ready_o = w_pick_any ? w_pick_gnt : '0;
        w_gnt_idx   = w_pick_idx;
      end
      LOCK: begin
        w_gnt_idx = r_owner;
        if (req_valid_i[r_owner]) begin
          req_ready_o[r_owner] = 1'b1;
        end else begin
          req_ready_o = '0;
        end
      end
      default: begin
        req_ready_o = '0;
        w_gnt_idx   = '0;
      end
    endcase
  end

  assign w_accept   = |req_ready_o;
  assign w_hold_inc = r_hold + HOLD_W'(1);

  // Next state, pointer, lock owner and hold count
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    case (r_state)
      ARB: begin
        if (w_accept) begin
          if (req_lock_i[w_gnt_idx] && (MAX_HOLD > 32'd1)) begin
            w_state_nxt = LOCK;
            w_owner_nxt = w_gnt_idx;
            w_hold_nxt  = HOLD_W'(1);
          end else begin
            w_ptr_nxt = next_idx(w_gnt_idx);
          end
        end else begin
          w_state_nxt = ARB;
        end
      end
      LOCK: begin
        if (w_accept) begin
          if (!req_lock_i[r_owner] || (w_hold_inc >= HOLD_W'(MAX_HOLD))) begin
            w_state_nxt = ARB;
            w_ptr_nxt   = next_idx(r_owner);
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end else if (!req_lock_i[r_owner]) begin
          // Burst abandoned while stalled: release and move past the owner.
          w_state_nxt = ARB;
          w_ptr_nxt   = next_idx(r_owner);
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = LOCK;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_ptr_nxt   = '0;
        w_owner_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Registered macro port; address/data/byte-enables hold when idle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_mem_idx   <= '0;
    end else if (w_accept) begin
      r_mem_cs    <= 1'b1;
      r_mem_we    <= req_we_i[w_gnt_idx];
      r_mem_addr  <= req_addr_i[w_gnt_idx];
      r_mem_be    <= req_be_i[w_gnt_idx];
      r_mem_wdata <= req_wdata_i[w_gnt_idx];
      r_mem_idx   <= w_gnt_idx;
    end else begin
      r_mem_cs <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  // Read tracking pipe, fed from the beat currently on the macro port
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < READ_LATENCY; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0].valid <= r_mem_cs && !r_mem_we;
      r_pipe[0].idx   <= IDX_MAX_W'(r_mem_idx);
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  // Route the oldest tracked read to its issuer
  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_pipe[READ_LATENCY-1].valid && (r_pipe[READ_LATENCY-1].idx == IDX_MAX_W'(i))) begin
        rsp_valid_o[i] = 1'b1;
      end else begin
        rsp_valid_o[i] = 1'b0;
      end
    end
  end

  assign rsp_rdata_o = mem_rdata_i;
  assign mem_cs_o    = r_mem_cs;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_be_o    = r_mem_be;
  assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Self-checking bench for sram_bank_arbiter: a transaction-level model
// (grant rules, golden memory, expected-response queue) checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_sram_bank_arbiter;

  localparam int N    = 2;
  localparam int AW   = 16;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;
  localparam int RL   = 2;
  localparam int MH   = 8;
  localparam int MAXC = 512;
  localparam logic [AW-1:0] PRE_ADDR = 16'h0010;
  localparam logic [DW-1:0] PRE_DATA = 64'h0000_0000_0000_DEAD;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] req_valid_i, req_ready_o, req_we_i, req_lock_i, rsp_valid_o;
  logic [N-1:0][AW-1:0] req_addr_i;
  logic [N-1:0][DW-1:0] req_wdata_i;
  logic [N-1:0][BW-1:0] req_be_i;
  logic [DW-1:0] rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic mem_cs_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;

  sram_bank_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_HOLD(MH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_lock_i(req_lock_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_be_i(req_be_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    forever #5 clk_i = ~clk_i;
  end

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  function automatic int decode(input logic [N-1:0] v);
    int r;
    r = -1;
    if (v != '0) begin
      r = -2;
      if ($onehot(v)) begin
        for (int i = 0; i < N; i++) if (v[i]) r = i;
      end
    end
    return r;
  endfunction

  // ---------------- behavioural SRAM macro driving mem_rdata_i ----------------
  logic [DW-1:0] macro_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_pipe [RL];
  assign mem_rdata_i = rd_pipe[RL-1];

  function automatic logic [DW-1:0] peek_macro(input logic [AW-1:0] a);
    return macro_mem.exists(a) ? macro_mem[a] : '0;
  endfunction

  initial begin
    macro_mem[PRE_ADDR] = PRE_DATA;
    for (int k = 0; k < RL; k++) rd_pipe[k] = 64'hBAD0_BAD0_BAD0_BAD0;
    forever begin
      @(posedge clk_i);
      for (int k = RL - 1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
      if (mem_cs_o && !mem_we_o) rd_pipe[0] = peek_macro(mem_addr_o);
      else rd_pipe[0] = {$urandom, $urandom};
      if (mem_cs_o && mem_we_o)
        macro_mem[mem_addr_o] = merge(peek_macro(mem_addr_o), mem_wdata_o, mem_be_o);
    end
  end

  // ---------------- transaction-level model and per-cycle compare ----------------
  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] gold [logic [AW-1:0]];
  rsp_t rq[$];
  int m_ptr = 0, m_owner = -1, m_hold = 0;
  logic e_cs = 1'b0, e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [BW-1:0] e_be = '0;
  logic [DW-1:0] e_wdata = '0;

  int            grant_log [MAXC];
  logic [N-1:0]  rspv_log  [MAXC];
  logic [DW-1:0] rspd_log  [MAXC];
  logic          cs_log    [MAXC];
  logic          we_log    [MAXC];

  function automatic logic [DW-1:0] peek_gold(input logic [AW-1:0] a);
    return gold.exists(a) ? gold[a] : '0;
  endfunction

  initial begin
    int eg;
    logic [N-1:0] exp_v;
    logic [DW-1:0] exp_d;
    rsp_t e;
    gold[PRE_ADDR] = PRE_DATA;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (cyc < MAXC) begin
        grant_log[cyc] = decode(req_ready_o);
        rspv_log[cyc]  = rsp_valid_o;
        rspd_log[cyc]  = rsp_rdata_o;
        cs_log[cyc]    = mem_cs_o;
        we_log[cyc]    = mem_we_o;
      end
      if (!rst_ni) begin
        m_ptr = 0; m_owner = -1; m_hold = 0;
        e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
        rq.delete();
      end else begin
        eg = -1;
        if (m_owner >= 0) begin
          if (req_valid_i[m_owner]) eg = m_owner;
        end else begin
          for (int k = 0; k < N; k++)
            if (eg < 0 && req_valid_i[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
        end
        check("req_ready", 64'(req_ready_o), (eg < 0) ? 64'd0 : (64'd1 << eg));
        check("mem_cs", 64'(mem_cs_o), 64'(e_cs));
        check("mem_we", 64'(mem_we_o), 64'(e_we));
        check("mem_addr", 64'(mem_addr_o), 64'(e_addr));
        check("mem_be", 64'(mem_be_o), 64'(e_be));
        check("mem_wdata", mem_wdata_o, e_wdata);
        exp_v = '0;
        exp_d = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          e = rq.pop_front();
          exp_v = N'(1) << e.idx;
          exp_d = e.data;
        end
        check("rsp_valid", 64'(rsp_valid_o), 64'(exp_v));
        if (exp_v != '0) check("rsp_rdata", rsp_rdata_o, exp_d);
        if (eg >= 0) begin
          e_cs = 1'b1;
          e_we = req_we_i[eg];
          e_addr = req_addr_i[eg];
          e_be = req_be_i[eg];
          e_wdata = req_wdata_i[eg];
          if (req_we_i[eg]) gold[req_addr_i[eg]] = merge(peek_gold(req_addr_i[eg]), req_wdata_i[eg], req_be_i[eg]);
          else rq.push_back('{cyc + 1 + RL, eg, peek_gold(req_addr_i[eg])});
          if (m_owner < 0) begin
            if (req_lock_i[eg] && MH > 1) begin
              m_owner = eg; m_hold = 1;
            end else begin
              m_ptr = (eg + 1) % N;
            end
          end else begin
            m_hold++;
            if (!req_lock_i[eg] || m_hold == MH) begin
              m_ptr = (eg + 1) % N; m_owner = -1; m_hold = 0;
            end
          end
        end else begin
          e_cs = 1'b0;
          e_we = 1'b0;
          if (m_owner >= 0 && !req_lock_i[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_hold = 0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk_i);
    #1;
    last_cyc = cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_all();
    req_valid_i = '0;
    req_lock_i = '0;
    req_we_i = '0;
  endtask

  task automatic drive(input int r, input logic v, input logic we, input logic lk,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid_i[r] = v;
    req_we_i[r] = we;
    req_lock_i[r] = lk;
    req_addr_i[r] = a;
    req_wdata_i[r] = d;
    req_be_i[r] = be;
  endtask

  initial begin
    int s, acc, w, pulses;
    int stall_c [7];
    int exp_stall [7] = '{0, 0, -1, -1, -1, 0, 1};
    idle_all();
    req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
    rst_ni = 1'b0;
    step(); step();
    rst_ni = 1'b1;
    step();
    check("rst_cs", 64'(mem_cs_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_rsp", 64'(rsp_valid_o), 64'd0);

    // Both valid, no lock: grants alternate 0,1,0,1...
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0040, 64'h0000_0000_0000_A0A0, 8'hFF);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0041, 64'h0, 8'hFF);
    step(); s = last_cyc;
    for (int t = 1; t < 6; t++) step();
    idle_all();
    for (int t = 0; t < 4; t++) step();
    check("alt_cs_before", 64'(cs_log[s]), 64'd0);
    for (int t = 0; t < 6; t++) begin
      check("alt_grant", 64'(grant_log[s + t]), 64'(t % 2));
      check("alt_cs", 64'(cs_log[s + t + 1]), 64'd1);
    end

    // Single read of preloaded word returns to req0 after 1+RL cycles
    drive(0, 1'b1, 1'b0, 1'b0, PRE_ADDR, 64'h0, 8'hFF);
    step(); acc = last_cyc;
    idle_all();
    for (int t = 0; t < 5; t++) step();
    check("rd_rsp_valid", 64'(rspv_log[acc + 3]), 64'd1);
    check("rd_rsp_data", rspd_log[acc + 3], 64'h0000_0000_0000_DEAD);
    pulses = 0;
    for (int t = 0; t <= 5; t++) pulses += (rspv_log[acc + t] != '0) ? 1 : 0;
    check("rd_pulses", 64'(pulses), 64'd1);

    // Locked req1 gets exactly MAX_HOLD grants, then req0
    drive(1, 1'b1, 1'b0, 1'b1, 16'h0050, 64'h0, 8'hFF);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0051, 64'h0, 8'hFF);
    step(); s = last_cyc;
    for (int t = 1; t < 9; t++) step();
    idle_all();
    for (int t = 0; t < 4; t++) step();
    for (int t = 0; t < 8; t++) check("lock_grant", 64'(grant_log[s + t]), 64'd1);
    check("lock_release", 64'(grant_log[s + 8]), 64'd0);

    // Burst stall: req0 locked drops valid, req1 must wait
    drive(0, 1'b1, 1'b0, 1'b1, 16'h0060, 64'h0, 8'hFF);
    step(); stall_c[0] = last_cyc;
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0061, 64'h0, 8'hFF);
    step(); stall_c[1] = last_cyc;
    req_valid_i[0] = 1'b0;
    for (int t = 2; t < 5; t++) begin step(); stall_c[t] = last_cyc; end
    req_valid_i[0] = 1'b1; req_lock_i[0] = 1'b0;
    step(); stall_c[5] = last_cyc;
    req_valid_i[0] = 1'b0;
    step(); stall_c[6] = last_cyc;
    idle_all();
    for (int t = 0; t < 4; t++) step();
    for (int t = 0; t < 7; t++) check("stall_grant", 64'(grant_log[stall_c[t]]), 64'(exp_stall[t]));

    // Write by req1 then read-back by req0
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0020, 64'h0000_0000_0000_1234, 8'hFF);
    step(); w = last_cyc;
    req_valid_i[1] = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0020, 64'h0, 8'hFF);
    step();
    idle_all();
    for (int t = 0; t < 5; t++) step();
    check("wr_grant", 64'(grant_log[w]), 64'd1);
    check("wr_we", 64'(we_log[w + 1]), 64'd1);
    check("wr_we_after", 64'(we_log[w + 2]), 64'd0);
    check("wr_rd_grant", 64'(grant_log[w + 1]), 64'd0);
    check("wr_rsp_valid", 64'(rspv_log[w + 4]), 64'd1);
    check("wr_rsp_data", rspd_log[w + 4], 64'h0000_0000_0000_1234);

    // Reset one cycle after a read accept drops the read and restarts the pointer
    drive(0, 1'b1, 1'b0, 1'b0, PRE_ADDR, 64'h0, 8'hFF);
    step(); acc = last_cyc;
    idle_all();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    check("rst2_cs", 64'(mem_cs_o), 64'd0);
    check("rst2_we", 64'(mem_we_o), 64'd0);
    check("rst2_addr", 64'(mem_addr_o), 64'd0);
    check("rst2_be", 64'(mem_be_o), 64'd0);
    check("rst2_wdata", mem_wdata_o, 64'd0);
    for (int t = 0; t < 4; t++) step();
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0070, 64'h0, 8'hFF);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0071, 64'h0, 8'hFF);
    step(); s = last_cyc;
    idle_all();
    for (int t = 0; t < 5; t++) step();
    pulses = 0;
    for (int t = 0; t <= 6; t++) pulses += (rspv_log[acc + t] != '0) ? 1 : 0;
    check("rst2_no_rsp", 64'(pulses), 64'd0);
    check("rst2_ptr", 64'(grant_log[s]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
Shares one SRAM bank-group port between NUM_REQ single-beat requesters (AXI SRAM front end, DMA, scrubber) using round-robin arbitration with optional grant locking for bursts. Drives registered chip-select, write-enable, address, byte-enable and write-data to the macros. Tracks reads through a READ_LATENCY-deep pipeline and routes each read result back to its issuer. Sits between the per-requester address generators and the bank_cs/bank_we/bank_rdata interface.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
ADDR_WIDTH, 16, bank word address width
DATA_WIDTH, 64, data width; byte enables are DATA_WIDTH/8 bits
READ_LATENCY, 2, cycles from mem_cs_o high (read) to valid mem_rdata_i (>=1)
MAX_HOLD, 8, maximum consecutive grants to one locked requester (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  NUM_REQ  request valid per requester
req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
req_we_i  in  NUM_REQ  1=write, 0=read
req_lock_i  in  NUM_REQ  keep grant for next beat (burst)
req_addr_i  in  NUM_REQ x ADDR_WIDTH  word address
req_wdata_i  in  NUM_REQ x DATA_WIDTH  write data
req_be_i  in  NUM_REQ x DATA_WIDTH/8  byte enables
rsp_valid_o  out  NUM_REQ  read data valid for requester (one-hot or zero)
rsp_rdata_o  out  DATA_WIDTH  read data, shared by all requesters
mem_cs_o  out  1  macro chip select
mem_we_o  out  1  macro write enable
mem_addr_o  out  ADDR_WIDTH  macro address
mem_be_o  out  DATA_WIDTH/8  macro byte enables
mem_wdata_o  out  DATA_WIDTH  macro write data
mem_rdata_i  in  DATA_WIDTH  macro read data

Behaviour:
- Reset (rst_ni=0 at clk_i edge): mem_cs_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0, rsp_valid_o=0, rr pointer=0, hold count=0, state=ARB, read pipeline cleared. In-flight reads are dropped and never respond.
- req_ready_o is combinational from req_valid_i and state. At most one bit is set. Handshake = valid&&ready. Requesters hold valid and payload stable until ready.
- One accept per cycle maximum; the port is fully pipelined with no bubbles between back-to-back accepts.
- Accept in cycle N: mem_* outputs are registered and show that beat in cycle N+1 with mem_cs_o=1. With no accept, mem_cs_o=0 and mem_we_o=0 next cycle; addr/wdata/be hold their values.
- Read accepted in cycle N: rsp_valid_o[i] and rsp_rdata_o=mem_rdata_i are combinational in cycle N+1+READ_LATENCY.
- Responses have no backpressure; requesters must sink them. Writes produce no response.
- The read pipeline is a READ_LATENCY-stage shift register of {valid, requester index}.
- States:
  - ARB: grant the first valid requester at or after the rr pointer, wrapping modulo NUM_REQ. On accept of requester g: if req_lock_i[g]=1 and MAX_HOLD>1, go to LOCK with hold count=1 and the pointer unchanged. Otherwise pointer=(g+1) mod NUM_REQ.
  - LOCK(g): only g may be granted. Each accept increments hold count.
    - Exit to ARB with pointer=(g+1) mod NUM_REQ when an accepted beat has req_lock_i[g]=0, or when hold count reaches MAX_HOLD on an accept.
    - If req_valid_i[g]=0 in LOCK, no grant is issued; the lock persists (burst data stall).
    - If req_lock_i[g]=0 while req_valid_i[g]=0, return to ARB.
- Pointer wrap: g=NUM_REQ-1 gives pointer 0.
- No valid requester: no grant, state unchanged.
- Simultaneous requests from all requesters: exactly one grant, in rotating order.

Decomposition:
- Package sram_arb_pkg: parameterised requester index width constant ($clog2(NUM_REQ)), state enum {ARB, LOCK}, and read-pipe entry struct {valid, idx}.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: one-hot grant and index.

Test Plan:
- NUM_REQ=2, both valid continuously, no lock -> grants alternate 0,1,0,1; mem_cs_o=1 every cycle starting one cycle after the first accept.
- Req0 reads addr 0x10 in cycle 5, READ_LATENCY=2, mem model returns 0xDEAD -> rsp_valid_o=01 and rsp_rdata_o=0xDEAD in cycle 8; no other rsp_valid_o pulse.
- Req1 holds lock with valid continuously, MAX_HOLD=8, req0 also valid -> req1 gets exactly 8 consecutive grants, then req0 is granted.
- Req0 locked, drops valid for 3 cycles while req1 is valid -> req1 is never granted during the stall; req0 resumes, deasserts lock on its last beat, then req1 is granted next cycle.
- Interleaved write by req1 to 0x20 (be=0xFF, data=0x1234) then read by req0 of 0x20 -> mem_we_o=1 for one cycle, then the read returns 0x1234 to req0 only.
- Reset asserted one cycle after a read accept -> all mem_* outputs 0 next edge, no rsp_valid_o for the dropped read, rr pointer restarts at 0.
